// File: rtl/conv_stream_sink.sv
// Output stage of the convolution pipeline: tags each filtered pixel with raster
// coordinates, replicates gray to RGB and buffers it in a FWFT FIFO for the frame writer.
module conv_stream_sink #(
  parameter int ROW_SIZE   = 1280,
  parameter int NUM_ROWS   = 960,
  parameter int PIXEL_SIZE = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_SIZE-1:0] pixel_in,
  input  logic                  valid_in,
  input  logic                  frame_start,
  output logic [PIXEL_SIZE-1:0] out_red,
  output logic [PIXEL_SIZE-1:0] out_green,
  output logic [PIXEL_SIZE-1:0] out_blue,
  output logic [10:0]           out_x,
  output logic [10:0]           out_y,
  output logic                  out_eof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  state_dbg
);

  // Handshake: the head entry transfers on a rising clk edge where out_valid && out_ready;
  // out_valid never depends combinationally on out_ready, and out_* hold while stalled.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PIXEL_SIZE + 11 + 11 + 1;
  localparam logic [10:0] X_LAST = 11'(ROW_SIZE - 1);
  localparam logic [10:0] Y_LAST = 11'(NUM_ROWS - 1);

  typedef enum logic {WAIT_SOF = 1'b0, STREAM = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [10:0] x_q, y_q, x_nxt, y_nxt;
  logic [10:0] tag_x, tag_y;
  logic        tag_eof, accept, resync_err;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, drop;
  logic [EW-1:0] head;

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_q;
    y_nxt      = y_q;
    tag_x      = x_q;
    tag_y      = y_q;
    tag_eof    = 1'b0;
    accept     = 1'b0;
    resync_err = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (valid_in && frame_start) begin
          accept    = 1'b1;
          tag_x     = '0;
          tag_y     = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (valid_in) begin
          accept = 1'b1;
          if (frame_start) begin
            tag_x      = '0;
            tag_y      = '0;
            resync_err = (x_q != '0) || (y_q != '0);
          end
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
    // Counters advance on every accepted pixel, even one the FIFO drops.
    if (accept) begin
      tag_eof = (tag_x == X_LAST) && (tag_y == Y_LAST);
      if (tag_eof) begin
        x_nxt     = '0;
        y_nxt     = '0;
        state_nxt = WAIT_SOF;
      end else if (tag_x == X_LAST) begin
        x_nxt = '0;
        y_nxt = tag_y + 11'd1;
      end else begin
        x_nxt = tag_x + 11'd1;
        y_nxt = tag_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = out_ready && !empty;
  // A full FIFO still takes a pixel when the head leaves in the same cycle.
  assign push  = accept && (!full || pop);
  assign drop  = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pixel_in, tag_x, tag_y, tag_eof};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= push && tag_eof;
      overflow   <= overflow | drop;
      frame_err  <= frame_err | resync_err;
    end
  end

  // Head fields are masked while empty so stale memory never shows on the outputs.
  assign head      = mem[rd_ptr];
  assign out_valid = !empty;
  assign out_red   = out_valid ? head[EW-1 -: PIXEL_SIZE] : '0;
  assign out_green = out_red;
  assign out_blue  = out_red;
  assign out_x     = out_valid ? head[22:12] : '0;
  assign out_y     = out_valid ? head[11:1]  : '0;
  assign out_eof   = out_valid & head[0];
  assign state_dbg = (state == STREAM);

endmodule

// File: tb/tb_conv_stream_sink.sv
// Directed bench for conv_stream_sink on a 4x2 frame with a 16-entry FIFO; expected
// output entries are queued at stimulus time and checked by an independent monitor.
module tb_conv_stream_sink;

  localparam int ROW_SIZE   = 4;
  localparam int NUM_ROWS   = 2;
  localparam int PIXEL_SIZE = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int EW         = PIXEL_SIZE + 23;

  logic                  clk;
  logic                  rst_n;
  logic [PIXEL_SIZE-1:0] pixel_in;
  logic                  valid_in;
  logic                  frame_start;
  logic [PIXEL_SIZE-1:0] out_red, out_green, out_blue;
  logic [10:0]           out_x, out_y;
  logic                  out_eof, out_valid, out_ready;
  logic                  frame_done, overflow, frame_err, state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  conv_stream_sink #(
    .ROW_SIZE(ROW_SIZE), .NUM_ROWS(NUM_ROWS),
    .PIXEL_SIZE(PIXEL_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .frame_start(frame_start), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .out_x(out_x), .out_y(out_y), .out_eof(out_eof),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .overflow(overflow), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    frame_start = 1'b0;
    pixel_in    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one pixel per call, expected entry queued when the FIFO should take it
  task automatic send(input logic [11:0] pix, input logic fs, input logic exp_push,
                      input logic [10:0] ex, input logic [10:0] ey, input logic eeof);
    valid_in    = 1'b1;
    pixel_in    = pix;
    frame_start = fs;
    if (exp_push) exp_q.push_back({pix, ex, ey, eeof});
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got pix=%0h x=%0d y=%0d, expected nothing", out_red, out_x, out_y);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_red",   64'(out_red),   64'(e[EW-1 -: PIXEL_SIZE]));
        check("out_green", 64'(out_green), 64'(e[EW-1 -: PIXEL_SIZE]));
        check("out_blue",  64'(out_blue),  64'(e[EW-1 -: PIXEL_SIZE]));
        check("out_x",     64'(out_x),     64'(e[22:12]));
        check("out_y",     64'(out_y),     64'(e[11:1]));
        check("out_eof",   64'(out_eof),   64'(e[0]));
      end
    end
  end

  always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

  initial begin
    out_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_red", 64'(out_red), 64'd0);
    check("rst_xy", 64'({out_x, out_y}), 64'd0);
    check("rst_eof", 64'(out_eof), 64'd0);
    check("rst_flags", 64'({frame_done, overflow, frame_err}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Pixels before any frame_start are discarded
    for (int i = 0; i < 10; i++) send(12'(i + 40), 1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t1_valid", 64'(out_valid), 64'd0);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_state", 64'(state_dbg), 64'd0);

    // One full 4x2 frame
    fd_cnt = 0;
    for (int i = 0; i < 8; i++)
      send(12'(i + 1), i == 0, 1'b1, 11'(i % 4), 11'(i / 4), i == 7);
    #1 check("t2_state_after_eof", 64'(state_dbg), 64'd0);
    send(12'h0ab, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
    wait_drain();
    check("t2_frame_done_cnt", 64'(fd_cnt), 64'd1);

    // Backpressure: 20 pixels into 16 entries, then resume aligned coordinates
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      send(12'(i + 1), (i % 8) == 0, i < 16, 11'(i % 4), 11'((i / 4) % 2), (i % 8) == 7);
    check("t3_valid_held", 64'(out_valid), 64'd1);
    check("t3_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    wait_drain();
    send(12'd21, 1'b0, 1'b1, 11'd0, 11'd1, 1'b0);
    send(12'd22, 1'b0, 1'b1, 11'd1, 11'd1, 1'b0);
    send(12'd23, 1'b0, 1'b1, 11'd2, 11'd1, 1'b0);
    send(12'd24, 1'b0, 1'b1, 11'd3, 11'd1, 1'b1);
    wait_drain();
    check("t3_state_end", 64'(state_dbg), 64'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send(12'(12'h200 + i), (i % 8) == 0, 1'b1, 11'(i % 4), 11'((i / 4) % 2), (i % 8) == 7);
    check("t4_ovf_full", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    send(12'h210, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0);
    out_ready = 1'b0;
    check("t4_ovf_pushpop", 64'(overflow), 64'd0);
    send(12'h211, 1'b0, 1'b0, 11'd1, 11'd0, 1'b0);
    check("t4_still_full", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // frame_start mid-frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(12'(12'h300 + i), i == 0, 1'b1, 11'(i), 11'd0, 1'b0);
    check("t5_err_before", 64'(frame_err), 64'd0);
    send(12'h304, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0);
    send(12'h305, 1'b0, 1'b1, 11'd1, 11'd0, 1'b0);
    send(12'h306, 1'b0, 1'b1, 11'd2, 11'd0, 1'b0);
    check("t5_frame_err", 64'(frame_err), 64'd1);
    wait_drain();

    // Async reset with 7 entries queued
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      send(12'(12'h400 + i), i == 0, 1'b1, 11'(i % 4), 11'(i / 4), 1'b0);
    check("t6_valid_before", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid_async", 64'(out_valid), 64'd0);
    check("t6_state_async", 64'(state_dbg), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(12'(12'h410 + i), 1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_valid_nosof", 64'(out_valid), 64'd0);
    send(12'h420, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0);
    check("t6_state_sof", 64'(state_dbg), 64'd1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
